// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl encodings shared by the ALU, its arbiter and the
// requesters of the multi-cycle MIPS core.
//   alu_op_t   : 5-bit ALUControl code
//   ALU_*      : code constants (ALU_PASS_A doubles as the idle code)
package alu_pkg;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALU_AND     = 5'b00000;
    localparam alu_op_t ALU_OR      = 5'b00001;
    localparam alu_op_t ALU_ADD     = 5'b00010;
    localparam alu_op_t ALU_XOR     = 5'b00011;
    localparam alu_op_t ALU_SLL     = 5'b00100;
    localparam alu_op_t ALU_SRL     = 5'b00101;
    localparam alu_op_t ALU_SUB     = 5'b00110;
    localparam alu_op_t ALU_SLT     = 5'b00111;
    localparam alu_op_t ALU_SRA     = 5'b01000;
    localparam alu_op_t ALU_SLTU    = 5'b01001;
    localparam alu_op_t ALU_EQ      = 5'b01010;
    localparam alu_op_t ALU_PASS_B  = 5'b01011;
    localparam alu_op_t ALU_LTZ     = 5'b01100;
    localparam alu_op_t ALU_JADD    = 5'b01101;
    localparam alu_op_t ALU_PASS_A  = 5'b01110;
    localparam alu_op_t ALU_LEZ     = 5'b10000;
    localparam alu_op_t ALU_JUMP    = 5'b10001;
    localparam alu_op_t ALU_LWL     = 5'b10010;
    localparam alu_op_t ALU_LWR     = 5'b10011;
    localparam alu_op_t ALU_LUI     = 5'b10100;
    localparam alu_op_t ALU_LWL_MEM = 5'b10101;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req [NREQ] : request bits
//   ptr [IW]   : index of the highest-priority requester this cycle
//   gnt [NREQ] : one-hot grant to the first set req bit at or after ptr
//                (wrapping), all zero when req is zero
//   idx [IW]   : index of the granted requester (0 when no grant)
module rr_picker #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic          found_s;
    logic [IW-1:0] cand_s;

    // Scan requesters in rotated order starting at ptr; first hit wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IW'((int'(ptr) + k) % NREQ);
            if (!found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
                found_s     = 1'b1;
            end else begin
                // an earlier requester in the rotation already won
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NREQ requesters.
//   clk, reset_n          : clock, synchronous active-low reset
//   req/lock [NREQ]       : per-requester request and keep-ownership flag
//   op/src_a/src_b        : per-requester ALUControl and operands (packed)
//   gnt [NREQ]            : combinational one-hot grant for this cycle
//   rsp_valid/rsp_data    : registered result, one cycle after the grant
//   alu_control/src_a/b   : drive the shared ALU; alu_result comes back
//   lock_active/owner     : registered lock state
// A granted requester with lock set keeps exclusive ownership until it issues
// an op with lock clear, or sits idle for LOCK_TIMEOUT consecutive cycles.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NREQ         = 2,
    parameter  int LOCK_TIMEOUT = 8,
    localparam int IW           = $clog2(NREQ),
    localparam int CW           = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [NREQ*5-1:0]   op,
    input  logic [NREQ*32-1:0]  src_a,
    input  logic [NREQ*32-1:0]  src_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [31:0]         rsp_data,
    output logic [4:0]          alu_control,
    output logic [31:0]         alu_src_a,
    output logic [31:0]         alu_src_b,
    input  logic [31:0]         alu_result,
    output logic                lock_active,
    output logic [IW-1:0]       lock_owner
);

    localparam logic [CW-1:0] IDLE_LAST = CW'(LOCK_TIMEOUT - 1);

    logic [IW-1:0]   ptr_r;
    logic            lock_active_r;
    logic [IW-1:0]   lock_owner_r;
    logic [CW-1:0]   idle_cnt_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [31:0]     rsp_data_r;

    logic [NREQ-1:0] pick_gnt_s;
    logic [IW-1:0]   pick_idx_s;
    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   win_idx_s;

    // Index after i, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end else begin
            return i + IW'(32'd1);
        end
    endfunction

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req (req),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // While locked only the owner may win; otherwise round-robin decides.
    always_comb begin
        gnt_s     = '0;
        win_idx_s = pick_idx_s;
        if (lock_active_r) begin
            gnt_s[lock_owner_r] = req[lock_owner_r];
            win_idx_s           = lock_owner_r;
        end else begin
            gnt_s = pick_gnt_s;
        end
    end

    // Route the winner's op and operands to the ALU; idle drives PASS_A of 0.
    always_comb begin
        alu_control = ALU_PASS_A;
        alu_src_a   = 32'd0;
        alu_src_b   = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                alu_control = op[5*i +: 5];
                alu_src_a   = src_a[32*i +: 32];
                alu_src_b   = src_b[32*i +: 32];
            end else begin
                // requester i not granted this cycle
            end
        end
    end

    // Round-robin pointer, lock ownership and idle-owner timeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r         <= '0;
            lock_active_r <= 1'b0;
            lock_owner_r  <= '0;
            idle_cnt_r    <= '0;
        end else if (|gnt_s) begin
            idle_cnt_r <= '0;
            if (lock[win_idx_s]) begin
                lock_active_r <= 1'b1;
                lock_owner_r  <= win_idx_s;
            end else begin
                lock_active_r <= 1'b0;
                ptr_r         <= wrap_inc(win_idx_s);
            end
        end else if (lock_active_r) begin
            // No grant while locked means the owner is not requesting.
            if (idle_cnt_r == IDLE_LAST) begin
                lock_active_r <= 1'b0;
                ptr_r         <= wrap_inc(lock_owner_r);
                idle_cnt_r    <= '0;
            end else begin
                idle_cnt_r <= idle_cnt_r + CW'(32'd1);
            end
        end else begin
            idle_cnt_r <= '0;
        end
    end

    // Capture the ALU result at the end of each grant cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= 32'd0;
        end else if (|gnt_s) begin
            rsp_valid_r <= gnt_s;
            rsp_data_r  <= alu_result;
        end else begin
            rsp_valid_r <= '0;
        end
    end

    assign gnt         = gnt_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign lock_active = lock_active_r;
    assign lock_owner  = lock_owner_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, self-checking bench for alu_arbiter (NREQ=2,
// LOCK_TIMEOUT=8). A small behavioural ALU closes the loop on alu_result;
// all expected values are hand-computed constants.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [9:0]  op;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  alu_control;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [31:0] alu_result;
    logic        lock_active;
    logic [0:0]  lock_owner;

    int          vectors     = 0;
    int          miscompares = 0;
    int          g0;
    int          g1;
    logic [1:0]  exp_g;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2), .LOCK_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .lock        (lock),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_result  (alu_result),
        .lock_active (lock_active),
        .lock_owner  (lock_owner)
    );

    // Minimal shared ALU: enough opcodes to give distinct results.
    always_comb begin
        case (alu_control)
            ALU_ADD:    alu_result = alu_src_a + alu_src_b;
            ALU_SUB:    alu_result = alu_src_a - alu_src_b;
            ALU_PASS_A: alu_result = alu_src_a;
            default:    alu_result = alu_src_a ^ alu_src_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
        op[5*i +: 5]     = o;
        src_a[32*i +: 32] = a;
        src_b[32*i +: 32] = b;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 2'b00;
        lock    = 2'b00;
        op      = 10'd0;
        src_a   = 64'd0;
        src_b   = 64'd0;
        cyc;
        cyc;

        // Reset state
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ctl", 32'(alu_control), 32'h0E);
        chk("rst_srca", alu_src_a, 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'h0);
        chk("rst_rspd", rsp_data, 32'd0);
        chk("rst_lock", 32'(lock_active), 32'h0);
        chk("rst_owner", 32'(lock_owner), 32'h0);

        // Both request: requester 0 first, then 1, results one cycle later
        reset_n = 1'b1;
        req = 2'b11;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        set_req(1, ALU_SUB, 32'd9, 32'd4);
        #1;
        chk("c1_gnt", 32'(gnt), 32'h1);
        chk("c1_ctl", 32'(alu_control), 32'h02);
        chk("c1_srca", alu_src_a, 32'd5);
        chk("c1_srcb", alu_src_b, 32'd7);
        cyc;
        chk("c2_rspv", 32'(rsp_valid), 32'h1);
        chk("c2_rspd", rsp_data, 32'd12);
        req = 2'b10;
        #1;
        chk("c2_gnt", 32'(gnt), 32'h2);
        chk("c2_ctl", 32'(alu_control), 32'h06);
        cyc;
        chk("c3_rspv", 32'(rsp_valid), 32'h2);
        chk("c3_rspd", rsp_data, 32'd5);

        // Idle: PASS_A of zero, result holds
        req = 2'b00;
        #1;
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_ctl", 32'(alu_control), 32'h0E);
        chk("idle_srca", alu_src_a, 32'd0);
        chk("idle_srcb", alu_src_b, 32'd0);
        cyc;
        chk("idle_rspv", 32'(rsp_valid), 32'h0);
        chk("idle_rspd", rsp_data, 32'd5);

        // Fairness: continuous requests alternate starting at requester 0
        req = 2'b11;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_SUB, 32'd10, 32'd3);
        g0 = 0;
        g1 = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("fair_gnt", 32'(gnt), 32'(exp_g));
            if (gnt == 2'b01) begin
                g0++;
            end else if (gnt == 2'b10) begin
                g1++;
            end
            cyc;
            chk("fair_rspv", 32'(rsp_valid), 32'(exp_g));
        end
        chk("fair_cnt0", 32'(g0), 32'd5);
        chk("fair_cnt1", 32'(g1), 32'd5);
        chk("fair_rspd", rsp_data, 32'd7);

        // Lock: move pointer to 1, then requester 1 owns two consecutive ops
        req = 2'b01;
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        #1;
        chk("lk_pre_gnt", 32'(gnt), 32'h1);
        cyc;
        req  = 2'b11;
        lock = 2'b10;
        set_req(1, ALU_LWL_MEM, 32'h1000, 32'h3);
        #1;
        chk("lk1_gnt", 32'(gnt), 32'h2);
        chk("lk1_act", 32'(lock_active), 32'h0);
        chk("lk1_ctl", 32'(alu_control), 32'h15);
        cyc;
        chk("lk2_act", 32'(lock_active), 32'h1);
        chk("lk2_owner", 32'(lock_owner), 32'h1);
        chk("lk2_rspd", rsp_data, 32'h1003);
        lock = 2'b00;
        set_req(1, ALU_LWL, 32'hAA00, 32'h00BB);
        #1;
        chk("lk2_gnt", 32'(gnt), 32'h2);
        chk("lk2_ctl", 32'(alu_control), 32'h12);
        cyc;
        chk("lk3_act", 32'(lock_active), 32'h0);
        chk("lk3_rspv", 32'(rsp_valid), 32'h2);
        chk("lk3_rspd", rsp_data, 32'hAABB);
        req = 2'b01;
        #1;
        chk("lk3_gnt", 32'(gnt), 32'h1);
        cyc;

        // Timeout: requester 0 locks then goes idle while requester 1 waits
        lock = 2'b01;
        #1;
        chk("to_lk_gnt", 32'(gnt), 32'h1);
        cyc;
        chk("to_act", 32'(lock_active), 32'h1);
        chk("to_owner", 32'(lock_owner), 32'h0);
        req  = 2'b10;
        lock = 2'b00;
        set_req(1, ALU_ADD, 32'd100, 32'd23);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("to_idle_gnt", 32'(gnt), 32'h0);
            chk("to_idle_act", 32'(lock_active), 32'h1);
            cyc;
        end
        chk("to_rel_act", 32'(lock_active), 32'h0);
        chk("to_rel_gnt", 32'(gnt), 32'h2);
        cyc;
        chk("to_rspv", 32'(rsp_valid), 32'h2);
        chk("to_rspd", rsp_data, 32'd123);

        // Reset while locked with a response pending
        lock = 2'b10;
        #1;
        chk("rl_gnt", 32'(gnt), 32'h2);
        cyc;
        chk("rl_act", 32'(lock_active), 32'h1);
        chk("rl_rspv", 32'(rsp_valid), 32'h2);
        reset_n = 1'b0;
        cyc;
        reset_n = 1'b1;
        req  = 2'b11;
        lock = 2'b00;
        #1;
        chk("rl_post_act", 32'(lock_active), 32'h0);
        chk("rl_post_rspv", 32'(rsp_valid), 32'h0);
        chk("rl_post_rspd", rsp_data, 32'd0);
        chk("rl_post_gnt", 32'(gnt), 32'h1);
        cyc;
        chk("rl_rspv2", 32'(rsp_valid), 32'h1);
        chk("rl_rspd2", rsp_data, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
